// File: rtl/la_clkdivsel_if.sv
// Ratio-update handshake between a requester and la_clkdivsel.
// The requester holds req and div stable until ack.
// busy is high while an accepted update waits for a period boundary.
interface la_clkdivsel_if #(
   parameter int DW = 8
);
   logic          req;
   logic [DW-1:0] div;
   logic          ack;
   logic          busy;

   modport master (output req, output div, input ack, input busy);
   modport slave  (input req, input div, output ack, output busy);
endinterface

// File: rtl/la_clkdivsel.sv
// Glitch-free programmable clock divider/selector.
// Ratio changes and stop/start are applied only at period boundaries.
// This keeps every high and low phase at its full length.
// Optional build macro LA_CLKDIVSEL_ODD50_EN gives odd ratios a 50% duty
// cycle. It adds a negedge flop that stretches the high phase by half a cycle.
module la_clkdivsel #(
   parameter     PROP        = "DEFAULT",
   parameter int DW          = 8,
   parameter int DEFAULT_DIV = 2
) (
   input  logic           clk,
   input  logic           nreset,
   input  logic           en,
   la_clkdivsel_if.slave  hs,
   output logic           running,
   output logic           out
);

   localparam logic [1:0] ST_STOP = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_PEND = 2'd2;

   localparam logic [DW-1:0] DIV_RST = DW'(DEFAULT_DIV);

   // This generic build uses no library cells. PROP is kept so that mapped
   // variants have the same parameter list.
   if (PROP == "") begin : g_prop_unset
   end

   logic [1:0]    state_q, state_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] ratio_q, ratio_d;
   logic [DW-1:0] div_lat_q, div_lat_d;
   logic          out_q, out_d;
   logic          ack_q, ack_d;

   logic          boundary;
   logic          accept;
   logic [DW-1:0] cnt_inc;
   logic [DW-1:0] half;

   // A ratio of 1 cannot make a glitch-free clock, so it is raised to 2.
   function automatic logic [DW-1:0] clamp_div(input logic [DW-1:0] d);
      return (d == DW'(1)) ? DW'(2) : d;
   endfunction

   // Next-state, counter and output logic. out_d follows the position of
   // cnt_d within the period.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ratio_d   = ratio_q;
      div_lat_d = div_lat_q;
      out_d     = 1'b0;
      ack_d     = 1'b0;
      half      = ratio_q >> 1;
      boundary  = (cnt_q == ratio_q - DW'(1));
      cnt_inc   = boundary ? '0 : cnt_q + DW'(1);
      accept    = hs.req && !ack_q && (state_q != ST_PEND);

      case (state_q)
         ST_STOP: begin
            cnt_d = '0;
            // A request takes priority, so the new ratio is in place
            // before the first period starts.
            if (accept) begin
               ratio_d = clamp_div(hs.div);
               ack_d   = 1'b1;
            end else if (en && (ratio_q != '0)) begin
               state_d = ST_RUN;
               out_d   = 1'b1;
            end
         end
         ST_RUN: begin
            if (boundary && (!en || (ratio_q == '0))) begin
               state_d = ST_STOP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
               out_d = (cnt_inc < half);
               if (accept) begin
                  div_lat_d = clamp_div(hs.div);
                  state_d   = ST_PEND;
               end
            end
         end
         ST_PEND: begin
            if (boundary) begin
               cnt_d   = '0;
               ratio_d = div_lat_q;
               ack_d   = 1'b1;
               if (!en || (div_lat_q == '0)) begin
                  state_d = ST_STOP;
               end else begin
                  state_d = ST_RUN;
                  out_d   = 1'b1;
               end
            end else begin
               cnt_d = cnt_inc;
               out_d = (cnt_inc < half);
            end
         end
         default: begin
            state_d = ST_STOP;
            cnt_d   = '0;
         end
      endcase
   end

   // State registers. An async reset forces out low at once.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q   <= ST_STOP;
         cnt_q     <= '0;
         ratio_q   <= DIV_RST;
         div_lat_q <= '0;
         out_q     <= 1'b0;
         ack_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ratio_q   <= ratio_d;
         div_lat_q <= div_lat_d;
         out_q     <= out_d;
         ack_q     <= ack_d;
      end
   end

   assign hs.ack  = ack_q;
   assign hs.busy = (state_q == ST_PEND);
   assign running = (state_q == ST_RUN) || (state_q == ST_PEND);

`ifdef LA_CLKDIVSEL_ODD50_EN
   logic out_n_q, out_n_d;

   // For odd ratios only, hold the high phase half a cycle longer.
   always_comb out_n_d = out_q & ratio_q[0];

   // Negedge copy of the posedge output.
   always_ff @(negedge clk or negedge nreset) begin
      if (!nreset) out_n_q <= 1'b0;
      else         out_n_q <= out_n_d;
   end

   assign out = out_q | out_n_q;
`else
   assign out = out_q;
`endif

endmodule
